// File: rtl/divider_8by4.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor,
// one quotient bit per clock, start/done handshake, single-module FSM + datapath.
module divider_8by4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int RW = DIVISOR_W + 1;
  localparam int CW = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;

  logic [DIVIDEND_W-1:0] a_q;
  logic [DIVISOR_W-1:0]  d_q;
  logic [DIVISOR_W-1:0]  r_q;
  logic [CW-1:0]         cnt_q;

  logic [RW-1:0]         trial;
  logic [DIVISOR_W-1:0]  diff;
  logic [DIVISOR_W-1:0]  r_nxt;
  logic [DIVIDEND_W-1:0] a_nxt;
  logic                  qbit;
  logic                  last;
  logic                  zero_div;

  // The partial remainder is always < D after an iteration, so its top bit is
  // never set and only the low DIVISOR_W bits need storing. The trial value
  // still gets the full 5-bit compare; the subtraction result fits in 4 bits.
  assign trial    = {r_q, a_q[DIVIDEND_W-1]};
  assign qbit     = (trial >= {1'b0, d_q});
  assign diff     = trial[DIVISOR_W-1:0] - d_q;
  assign r_nxt    = qbit ? diff : trial[DIVISOR_W-1:0];
  assign a_nxt    = {a_q[DIVIDEND_W-2:0], qbit};
  assign last     = (cnt_q == CW'(DIVIDEND_W - 1));
  assign zero_div = (divisor == '0);

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = zero_div ? DONE : CALC;
      CALC: if (last)  state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              a_q         <= dividend;
              d_q         <= divisor;
              r_q         <= '0;
              cnt_q       <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          a_q   <= a_nxt;
          r_q   <= r_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            quotient  <= a_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8by4.sv
// Directed bench for divider_8by4: latency, busy window, boundaries, div-by-zero,
// handshake robustness, async reset mid-run and the 4x4 multiplier round trip.
module tb_divider_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  divider_8by4 #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; raises start for one edge, then
  // samples at each negedge until done (bounded). Returns at the negedge after
  // done, so the next call yields the minimum 10-cycle start spacing.
  task automatic run(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                     input logic [7:0] exp_q, input logic [3:0] exp_r,
                     input logic exp_z, input int exp_lat, input bit full);
    int lat;
    int bcnt;
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      bcnt += busy;
      @(negedge clk);
      lat++;
    end
    if (full) begin
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy_cycles"}, bcnt, exp_lat - 1);
      chk({tag, " dbz"}, div_by_zero, exp_z);
    end
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " remainder"}, remainder, exp_r);
    @(negedge clk);
    if (full) begin
      chk({tag, " done_pulse_one_cycle"}, done, 1'b0);
      chk({tag, " quotient_hold"}, quotient, exp_q);
    end
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quotient", quotient, 8'h00);
    chk("reset remainder", remainder, 4'h0);
    chk("reset dbz", div_by_zero, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run("nominal 200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b1);
    run("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 1'b1);
    run("255/15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9, 1'b1);
    run("5/9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 9, 1'b1);
    run("0/3", 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 9, 1'b1);
    run("100/0", 8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1, 1'b1);
    run("100/10", 8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 9, 1'b1);

    // Handshake robustness: stray start and input changes mid-run.
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) begin start = 1'b1; dividend = 8'd9; divisor = 4'd3; end
      if (c == 4) begin start = 1'b0; dividend = 8'd50; divisor = 4'd2; end
      if (done) begin
        dcnt++;
        chk("hs quotient", quotient, 8'd28);
        chk("hs remainder", remainder, 4'd4);
      end
      @(negedge clk);
    end
    chk("hs done_count", dcnt, 1);

    // Async reset during CALC of a 77/6 run.
    start = 1'b1; dividend = 8'd77; divisor = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst pre busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst async busy", busy, 1'b0);
    chk("rst async done", done, 1'b0);
    chk("rst async quotient", quotient, 8'h00);
    chk("rst async remainder", remainder, 4'h0);
    chk("rst async dbz", div_by_zero, 1'b0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      dcnt += done;
      dcnt += busy;
      @(negedge clk);
    end
    chk("rst idle no_done_no_busy", dcnt, 0);
    run("77/6 after rst", 8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9, 1'b1);

    // Multiplier round trip.
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run($sformatf("rt %0d*%0d", a, b), 8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
